// File: rtl/mm_seq_pkg.sv
// mm_seq_pkg: shared definitions for the MM tile sequencer.
//   - FSM state encoding (legacy localparam constants, 3 bits)
//   - DRAIN_LAT: MM result latency after the last feature beat for the default
//     6-row array, plus the helper that derives it for other array heights.
// Optional feature macro used by files importing this package: MM_SEQ_PERF_EN.
package mm_seq_pkg;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWFlag = 3'd1;
  localparam logic [2:0] StWLoad = 3'd2;
  localparam logic [2:0] StWSet  = 3'd3;
  localparam logic [2:0] StXStrm = 3'd4;
  localparam logic [2:0] StDrain = 3'd5;

  localparam int unsigned ARRAY_M_DEFAULT = 6;

  // Result of the last row leaves the array after it crosses all rows twice
  // (skew in, skew out) plus the output register.
  function automatic int unsigned drain_lat(input int unsigned m);
    return 2 * m + 1;
  endfunction

  localparam int unsigned DRAIN_LAT = drain_lat(ARRAY_M_DEFAULT);

endpackage

// File: rtl/mm_seq_perf_cnt.sv
// mm_seq_perf_cnt: pair of saturating 32-bit event counters.
// Only instantiated by mm_tile_sequencer when MM_SEQ_PERF_EN is defined.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clr            synchronous clear of both counters (priority over increments)
//   inc_a, inc_b   increment enables
//   cnt_a, cnt_b   counter values, stick at all ones
module mm_seq_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        inc_a,
  input  logic        inc_b,
  output logic [31:0] cnt_a,
  output logic [31:0] cnt_b
);

  logic [31:0] cnt_a_q, cnt_b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else if (clr) begin
      cnt_a_q <= '0;
      cnt_b_q <= '0;
    end else begin
      if (inc_a && (cnt_a_q != '1)) cnt_a_q <= cnt_a_q + 32'd1;
      if (inc_b && (cnt_b_q != '1)) cnt_b_q <= cnt_b_q + 32'd1;
    end
  end

  assign cnt_a = cnt_a_q;
  assign cnt_b = cnt_b_q;

endmodule

// File: rtl/mm_tile_sequencer.sv
// mm_tile_sequencer: steps the MM systolic-array wrapper through weight-load,
// feature-stream and drain phases for cfg_tiles tiles of cfg_rows rows each.
// Optional feature: MM_SEQ_PERF_EN adds perf_cycles / perf_stalls outputs.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, cfg_rows/tiles    job launch; cfg latched on accepted start
//   busy, done, tile_idx     job status (done is a 1-cycle pulse)
//   w_t*, x_t*               weight / feature valid-ready streams in
//   mm_*  (out)              weight-phase flag, data, valid, last to the MM
//   mm_set_w, mm_out_last    MM handshakes: weights latched, tile result done
//   perf_cycles/stalls       busy cycles / stream stall cycles (MM_SEQ_PERF_EN)
module mm_tile_sequencer
  import mm_seq_pkg::*;
#(
  parameter int unsigned ARRAY_M    = 6,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ROW_W      = 16,
  parameter int unsigned TILE_W     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [ROW_W-1:0]              cfg_rows,
  input  logic [TILE_W-1:0]             cfg_tiles,
  output logic                          busy,
  output logic                          done,
  output logic [TILE_W-1:0]             tile_idx,
`ifdef MM_SEQ_PERF_EN
  output logic [31:0]                   perf_cycles,
  output logic [31:0]                   perf_stalls,
`endif
  input  logic [ARRAY_M*DATA_WIDTH-1:0] w_tdata,
  input  logic                          w_tvalid,
  output logic                          w_tready,
  input  logic [ARRAY_M*DATA_WIDTH-1:0] x_tdata,
  input  logic                          x_tvalid,
  output logic                          x_tready,
  output logic                          mm_wdata_flag_up,
  output logic [ARRAY_M*DATA_WIDTH-1:0] mm_in_data,
  output logic                          mm_in_data_valid,
  output logic                          mm_in_last,
  input  logic                          mm_set_w,
  input  logic                          mm_out_last
);

  localparam logic [ROW_W-1:0] WLastBeat = ROW_W'(ARRAY_M - 1);

  logic [2:0]        state_q, state_d;
  logic [ROW_W-1:0]  rows_q, rows_d;
  logic [TILE_W-1:0] tiles_q, tiles_d;
  logic [ROW_W-1:0]  cnt_q, cnt_d;    // beats accepted in the current phase
  logic [TILE_W-1:0] tile_q, tile_d;
  logic              done_q, done_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      rows_q  <= '0;
      tiles_q <= '0;
      cnt_q   <= '0;
      tile_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      tiles_q <= tiles_d;
      cnt_q   <= cnt_d;
      tile_q  <= tile_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    rows_d           = rows_q;
    tiles_d          = tiles_q;
    cnt_d            = cnt_q;
    tile_d           = tile_q;
    done_d           = 1'b0;
    w_tready         = 1'b0;
    x_tready         = 1'b0;
    mm_wdata_flag_up = 1'b0;
    mm_in_data       = '0;
    mm_in_data_valid = 1'b0;
    mm_in_last       = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          rows_d  = cfg_rows;
          tiles_d = cfg_tiles;
          cnt_d   = '0;
          tile_d  = '0;
          // Empty job: report completion without touching the MM.
          if ((cfg_rows == '0) || (cfg_tiles == '0)) done_d  = 1'b1;
          else                                       state_d = StWFlag;
        end
      end
      StWFlag: begin
        mm_wdata_flag_up = 1'b1;
        state_d          = StWLoad;
      end
      StWLoad: begin
        w_tready         = 1'b1;
        mm_in_data_valid = w_tvalid;
        if (w_tvalid) begin
          mm_in_data = w_tdata;
          if (cnt_q == WLastBeat) begin
            mm_in_last = 1'b1;
            cnt_d      = '0;
            state_d    = StWSet;
          end else begin
            cnt_d = cnt_q + ROW_W'(1);
          end
        end
      end
      StWSet: begin
        if (mm_set_w) state_d = StXStrm;
      end
      StXStrm: begin
        x_tready         = 1'b1;
        mm_in_data_valid = x_tvalid;
        if (x_tvalid) begin
          mm_in_data = x_tdata;
          // rows_q >= 1 here, so the subtraction cannot wrap.
          if (cnt_q == (rows_q - ROW_W'(1))) begin
            mm_in_last = 1'b1;
            cnt_d      = '0;
            state_d    = StDrain;
          end else begin
            cnt_d = cnt_q + ROW_W'(1);
          end
        end
      end
      StDrain: begin
        if (mm_out_last) begin
          if (tile_q == (tiles_q - TILE_W'(1))) begin
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            tile_d  = tile_q + TILE_W'(1);
            state_d = StWFlag;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign tile_idx = tile_q;

`ifdef MM_SEQ_PERF_EN
  logic start_acc;
  logic stall_cycle;

  assign start_acc   = (state_q == StIdle) && start;
  assign stall_cycle = ((state_q == StWLoad) && !w_tvalid) ||
                       ((state_q == StXStrm) && !x_tvalid);

  mm_seq_perf_cnt u_perf (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .inc_a (busy),
    .inc_b (stall_cycle),
    .cnt_a (perf_cycles),
    .cnt_b (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_mm_tile_sequencer.sv
// Testbench for mm_tile_sequencer: directed jobs against a small MM responder
// and a negedge monitor that tallies the sequencer's traffic.
module tb_mm_tile_sequencer;
  import mm_seq_pkg::*;

  localparam int ARRAY_M = 6;
  localparam int DW      = 8;
  localparam int BW      = ARRAY_M * DW;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [15:0]   cfg_rows;
  logic [7:0]    cfg_tiles;
  logic          busy, done;
  logic [7:0]    tile_idx;
  logic [BW-1:0] w_tdata = '0;
  logic          w_tvalid;
  logic          w_tready;
  logic [BW-1:0] x_tdata = '0;
  logic          x_tvalid = 1'b1;
  logic          x_tready;
  logic          mm_wdata_flag_up;
  logic [BW-1:0] mm_in_data;
  logic          mm_in_data_valid;
  logic          mm_in_last;
  logic          mm_set_w = 1'b0;
  logic          mm_out_last = 1'b0;
`ifdef MM_SEQ_PERF_EN
  logic [31:0]   perf_cycles, perf_stalls;
`endif

  always #5 clk = ~clk;

  mm_tile_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_rows         (cfg_rows),
    .cfg_tiles        (cfg_tiles),
    .busy             (busy),
    .done             (done),
    .tile_idx         (tile_idx),
`ifdef MM_SEQ_PERF_EN
    .perf_cycles      (perf_cycles),
    .perf_stalls      (perf_stalls),
`endif
    .w_tdata          (w_tdata),
    .w_tvalid         (w_tvalid),
    .w_tready         (w_tready),
    .x_tdata          (x_tdata),
    .x_tvalid         (x_tvalid),
    .x_tready         (x_tready),
    .mm_wdata_flag_up (mm_wdata_flag_up),
    .mm_in_data       (mm_in_data),
    .mm_in_data_valid (mm_in_data_valid),
    .mm_in_last       (mm_in_last),
    .mm_set_w         (mm_set_w),
    .mm_out_last      (mm_out_last)
  );

  int tests = 0;
  int fails = 0;

  // Scenario knobs, written only by the test tasks.
  int exp_rows  = 0;
  int stall_at  = 0;
  int stall_len = 0;
  logic spur_outl = 1'b0;

  // Monitor tallies, written only by the monitor.
  int cyc = 0, t_outl = -100;
  int n_flag = 0, n_done = 0, n_busy = 0, n_valid = 0;
  int n_wrdy = 0, n_wbeat = 0, n_wlast = 0, n_xrdy = 0, n_xbeat = 0, n_xlast = 0;
  int n_bubble = 0, data_bad = 0, zero_bad = 0, both_bad = 0;
  int wlast_bad = 0, xlast_bad = 0, tile_bad = 0, gap_bad = 0;
  int wbeat = 0, xbeat = 0, exp_tile = 0, setw_cnt = 0, outl_cnt = 0, stall_used = 0;
  logic [BW-1:0] mon_exp;

  // Snapshots taken at the start of each scenario.
  int s_flag, s_done, s_busy, s_valid, s_wrdy, s_wbeat, s_wlast, s_xrdy, s_xbeat, s_xlast;
  int s_bubble, s_data, s_zero, s_both, s_wlb, s_xlb, s_tile, s_gap;

  // Sample at negedge, then update the MM responder and stream sources.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      setw_cnt = 0; outl_cnt = 0; exp_tile = 0; wbeat = 0; xbeat = 0; stall_used = 0;
      mm_set_w = 1'b0; mm_out_last = 1'b0; x_tvalid = 1'b1;
    end else begin
      if (busy) n_busy++;
      if (done) begin
        n_done++;
        if (exp_tile != 0 && (cyc - t_outl) != 1) gap_bad++;
        exp_tile = 0;
      end
      if (mm_wdata_flag_up) begin
        n_flag++;
        if (tile_idx !== 8'(exp_tile)) tile_bad++;
        if (exp_tile != 0 && (cyc - t_outl) != 1) gap_bad++;
        exp_tile++; wbeat = 0; xbeat = 0; stall_used = 0;
      end
      if (mm_in_data_valid) begin
        n_valid++;
        mon_exp = w_tready ? w_tdata : x_tdata;
        if (mm_in_data !== mon_exp) data_bad++;
      end else if (mm_in_data !== '0) zero_bad++;
      if (w_tready && x_tready) both_bad++;
      if (w_tready) begin
        n_wrdy++;
        if (w_tvalid) begin
          wbeat++; n_wbeat++;
          if (mm_in_last) begin
            n_wlast++; setw_cnt = 2;
            if (wbeat != ARRAY_M) wlast_bad++;
          end
        end
      end
      if (x_tready) begin
        n_xrdy++;
        if (!x_tvalid) n_bubble++;
        else begin
          xbeat++; n_xbeat++;
          if (mm_in_last) begin
            n_xlast++; outl_cnt = DRAIN_LAT;
            if (xbeat != exp_rows) xlast_bad++;
          end
        end
      end
      mm_set_w = 1'b0; mm_out_last = 1'b0;
      if (setw_cnt != 0) begin setw_cnt--; if (setw_cnt == 0) mm_set_w = 1'b1; end
      if (outl_cnt != 0) begin
        outl_cnt--;
        if (outl_cnt == 0) begin mm_out_last = 1'b1; t_outl = cyc; end
      end
      if (spur_outl) mm_out_last = 1'b1;
      if (x_tready && xbeat == stall_at && stall_used < stall_len) begin
        x_tvalid = 1'b0; stall_used++;
      end else x_tvalid = 1'b1;
    end
    w_tdata = BW'({$urandom(), $urandom()});
    x_tdata = BW'({$urandom(), $urandom()});
  end

  task automatic snap();
    s_flag = n_flag; s_done = n_done; s_busy = n_busy; s_valid = n_valid;
    s_wrdy = n_wrdy; s_wbeat = n_wbeat; s_wlast = n_wlast; s_xrdy = n_xrdy;
    s_xbeat = n_xbeat; s_xlast = n_xlast; s_bubble = n_bubble; s_data = data_bad;
    s_zero = zero_bad; s_both = both_bad; s_wlb = wlast_bad; s_xlb = xlast_bad;
    s_tile = tile_bad; s_gap = gap_bad;
  endtask

  task automatic pulse_start(input int rows, input int tiles);
    @(posedge clk); #1;
    cfg_rows = 16'(rows); cfg_tiles = 8'(tiles); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget && n_done == s_done; i++) @(posedge clk);
    tests++;
    if (n_done == s_done) begin
      fails++; $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
    repeat (3) @(posedge clk);
  endtask

  task automatic run_job(input string name, input int rows, input int tiles,
                         input int s_at, input int s_len, input int budget);
    exp_rows = rows; stall_at = s_at; stall_len = s_len;
    snap();
    pulse_start(rows, tiles);
    wait_done(name, budget);
  endtask

  task automatic test_reset();
    rst = 1'b1; #3;
    tests++;
    if ({busy, done, tile_idx, w_tready, x_tready, mm_wdata_flag_up, mm_in_data_valid,
         mm_in_last} !== '0 || mm_in_data !== '0) begin
      fails++; $display("FAIL reset_outputs: busy=%b done=%b tile=%0d data=%h want all 0",
                        busy, done, tile_idx, mm_in_data);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (3) @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    run_job("basic", 4, 1, 0, 0, 200);
    tests++; if (n_flag - s_flag != 1) begin fails++;
      $display("FAIL basic_flag: got %0d want 1", n_flag - s_flag); end
    tests++; if (n_wbeat - s_wbeat != 6 || n_wrdy - s_wrdy != 6) begin fails++;
      $display("FAIL basic_wbeats: beats %0d ready %0d want 6", n_wbeat - s_wbeat, n_wrdy - s_wrdy); end
    tests++; if (n_wlast - s_wlast != 1 || wlast_bad != s_wlb) begin fails++;
      $display("FAIL basic_wlast: count %0d misplaced %0d want 1/0", n_wlast - s_wlast,
               wlast_bad - s_wlb); end
    tests++; if (n_xbeat - s_xbeat != 4 || n_xrdy - s_xrdy != 4) begin fails++;
      $display("FAIL basic_xbeats: beats %0d ready %0d want 4", n_xbeat - s_xbeat, n_xrdy - s_xrdy); end
    tests++; if (n_xlast - s_xlast != 1 || xlast_bad != s_xlb) begin fails++;
      $display("FAIL basic_xlast: count %0d misplaced %0d want 1/0", n_xlast - s_xlast,
               xlast_bad - s_xlb); end
    tests++; if (n_done - s_done != 1 || gap_bad != s_gap) begin fails++;
      $display("FAIL basic_done: count %0d late %0d want 1/0", n_done - s_done, gap_bad - s_gap); end
    tests++; if (data_bad != s_data || zero_bad != s_zero || both_bad != s_both) begin fails++;
      $display("FAIL basic_data: bad %0d nonzero %0d both_ready %0d want 0", data_bad - s_data,
               zero_bad - s_zero, both_bad - s_both); end
  endtask

  task automatic test_multi_tile();
    run_job("multi", 3, 3, 0, 0, 400);
    tests++; if (n_flag - s_flag != 3) begin fails++;
      $display("FAIL multi_flags: got %0d want 3", n_flag - s_flag); end
    tests++; if (tile_bad != s_tile) begin fails++;
      $display("FAIL multi_tile_idx: %0d wrong tile_idx at flag", tile_bad - s_tile); end
    tests++; if (gap_bad != s_gap) begin fails++;
      $display("FAIL multi_gap: %0d flag/done not 1 cycle after out_last", gap_bad - s_gap); end
    tests++; if (n_done - s_done != 1) begin fails++;
      $display("FAIL multi_done: got %0d want 1", n_done - s_done); end
    tests++; if (n_wbeat - s_wbeat != 18 || n_xbeat - s_xbeat != 9) begin fails++;
      $display("FAIL multi_beats: w %0d x %0d want 18/9", n_wbeat - s_wbeat, n_xbeat - s_xbeat); end
    tests++; if (tile_idx !== 8'd2) begin fails++;
      $display("FAIL multi_final_tile: got %0d want 2", tile_idx); end
  endtask

  task automatic test_stall();
    run_job("stall", 5, 1, 2, 2, 200);
    tests++; if (n_bubble - s_bubble != 2 || n_xrdy - s_xrdy != 7) begin fails++;
      $display("FAIL stall_bubbles: bubbles %0d ready %0d want 2/7", n_bubble - s_bubble,
               n_xrdy - s_xrdy); end
    tests++; if (zero_bad != s_zero || data_bad != s_data) begin fails++;
      $display("FAIL stall_data: nonzero %0d bad %0d want 0", zero_bad - s_zero, data_bad - s_data); end
    tests++; if (n_xlast - s_xlast != 1 || xlast_bad != s_xlb || n_xbeat - s_xbeat != 5) begin
      fails++; $display("FAIL stall_xlast: last %0d misplaced %0d beats %0d want 1/0/5",
                        n_xlast - s_xlast, xlast_bad - s_xlb, n_xbeat - s_xbeat); end
  endtask

  task automatic test_zero_cfg(input int rows, input int tiles);
    snap();
    pulse_start(rows, tiles);
    @(negedge clk);
    tests++; if (done !== 1'b1 || busy !== 1'b0) begin fails++;
      $display("FAIL zero_done_%0d_%0d: done=%b busy=%b want 1/0", rows, tiles, done, busy); end
    @(negedge clk);
    tests++; if (done !== 1'b0) begin fails++;
      $display("FAIL zero_pulse_%0d_%0d: done=%b want 0", rows, tiles, done); end
    repeat (4) @(posedge clk);
    tests++; if (n_flag != s_flag || n_valid != s_valid || n_busy != s_busy) begin fails++;
      $display("FAIL zero_traffic_%0d_%0d: flags %0d valids %0d busy %0d want 0", rows, tiles,
               n_flag - s_flag, n_valid - s_valid, n_busy - s_busy); end
  endtask

  task automatic test_start_ignored();
    exp_rows = 4; stall_at = 0; stall_len = 0;
    snap();
    pulse_start(4, 1);
    for (int i = 0; i < 100 && !x_tready; i++) begin @(posedge clk); #2; end
    // Restart with different cfg and a stray out_last while streaming.
    cfg_rows = 16'd1; cfg_tiles = 8'd5; start = 1'b1; spur_outl = 1'b1;
    @(posedge clk); #2;
    start = 1'b0; spur_outl = 1'b0;
    wait_done("ignore", 200);
    tests++; if (n_flag - s_flag != 1 || n_xbeat - s_xbeat != 4 || xlast_bad != s_xlb) begin
      fails++; $display("FAIL ignore_job: flags %0d xbeats %0d misplaced %0d want 1/4/0",
                        n_flag - s_flag, n_xbeat - s_xbeat, xlast_bad - s_xlb); end
    tests++; if (n_done - s_done != 1) begin fails++;
      $display("FAIL ignore_done: got %0d want 1", n_done - s_done); end
  endtask

  task automatic test_reset_mid();
    exp_rows = 4;
    snap();
    pulse_start(4, 2);
    for (int i = 0; i < 100 && !x_tready; i++) begin @(posedge clk); #2; end
    rst = 1'b1; #1;
    tests++;
    if ({busy, done, tile_idx, w_tready, x_tready, mm_wdata_flag_up, mm_in_data_valid,
         mm_in_last} !== '0 || mm_in_data !== '0) begin
      fails++; $display("FAIL rstmid_outputs: busy=%b x_tready=%b valid=%b want all 0",
                        busy, x_tready, mm_in_data_valid);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    tests++; if (n_done != s_done || busy !== 1'b0) begin fails++;
      $display("FAIL rstmid_nodone: done %0d busy %b want 0/0", n_done - s_done, busy); end
    run_job("rstmid_clean", 4, 1, 0, 0, 200);
    tests++; if (n_flag - s_flag != 1 || n_xbeat - s_xbeat != 4 || n_wbeat - s_wbeat != 6) begin
      fails++; $display("FAIL rstmid_clean: flags %0d w %0d x %0d want 1/6/4",
                        n_flag - s_flag, n_wbeat - s_wbeat, n_xbeat - s_xbeat); end
  endtask

  task automatic test_max_tiles();
    run_job("maxtile", 1, 255, 0, 0, 12000);
    tests++; if (n_flag - s_flag != 255 || tile_bad != s_tile) begin fails++;
      $display("FAIL maxtile_flags: got %0d bad_idx %0d want 255/0", n_flag - s_flag,
               tile_bad - s_tile); end
    tests++; if (n_done - s_done != 1 || tile_idx !== 8'd254) begin fails++;
      $display("FAIL maxtile_done: done %0d tile %0d want 1/254", n_done - s_done, tile_idx); end
  endtask

`ifdef MM_SEQ_PERF_EN
  task automatic test_perf();
    run_job("perf", 6, 1, 3, 3, 200);
    tests++; if (perf_stalls !== 32'd3) begin fails++;
      $display("FAIL perf_stalls: got %0d want 3", perf_stalls); end
    tests++; if (perf_cycles !== 32'(n_busy - s_busy)) begin fails++;
      $display("FAIL perf_cycles: got %0d want %0d", perf_cycles, n_busy - s_busy); end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; cfg_rows = '0; cfg_tiles = '0; w_tvalid = 1'b1;
    test_reset();
    test_basic();
    test_multi_tile();
    test_stall();
    test_zero_cfg(0, 3);
    test_zero_cfg(5, 0);
    test_start_ignored();
    test_reset_mid();
    test_max_tiles();
`ifdef MM_SEQ_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
